pipa_counter_sequencer: RTL and testbench
=========================================

# pipa_counter_sequencer

Schedules PIPA (pulsed integrating pendulous accelerometer) pulses into counter-cell increment cycles for the three PIPA counters. On each PIPSAM strobe it samples the active-low PIPA pulse lines and accumulates a signed pending count per axis. It then presents one PINC/MINC request at a time to the counter-cycle datapath, the A9-class register slice, using a request/acknowledge handshake with fixed X>Y>Z priority. It also flags illegal PIPA pulse pairs and pending-count saturation.

## Interface
Parameters:
- PEND_W, 4, width of each signed pending count (two's complement, range -8..+7).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- PIPSAM  in  1  sample strobe, one cycle wide.
- PIPAXp_, PIPAXm_, PIPAYp_, PIPAYm_, PIPAZp_, PIPAZm_  in  1 each  active-low PIPA pulse levels, valid when PIPSAM=1.
- CTRACK  in  1  datapath acknowledge: the current request was serviced this cycle.
- FLCLR  in  1  clears PIPAFL and PENDOV.
- CTRREQ  out  1  counter-cycle request.
- CTRADR  out  2  counter select: 0=X, 1=Y, 2=Z. The value 3 is never driven.
- PINC, MINC  out  1 each  increment direction. One-hot while CTRREQ=1, both 0 otherwise.
- PIPAFL  out  1  sticky flag: PIPA pulse pair fail.
- PENDOV  out  1  sticky flag: pending-count saturation.
- PENDX, PENDY, PENDZ  out  PEND_W each  pending counts, for debug/monitor.

## Operation
- Sampling, per axis, only when PIPSAM=1:
  - p_=0, m_=1 gives delta +1.
  - m_=0, p_=1 gives delta -1.
  - Both 1 gives delta 0.
  - Both 0 gives delta 0 and sets PIPAFL.
- Pending update, per axis, every cycle: new = old + sample_delta - ack_delta.
  - ack_delta is +1 if CTRACK completes a PINC on this axis, -1 for MINC, 0 otherwise.
  - The result saturates to [-8,+7]. Saturation sets PENDOV.
  - Sample and ack on the same axis in the same cycle are both applied. Example: +2, sample +1, PINC ack gives +2.
- State machine:
  - IDLE: if any registered pending count is nonzero, select the first nonzero axis in the order X, Y, Z. Latch its axis and its direction (PINC if positive, MINC if negative), then go to REQ. Otherwise stay in IDLE.
  - REQ: CTRREQ=1, CTRADR and PINC/MINC hold the latched values and stay stable until acknowledged, even if pending changes or reaches 0. On CTRACK=1, apply ack_delta with the latched direction and go to GAP. Without CTRACK, stay in REQ.
  - GAP: CTRREQ=0 for exactly one cycle, then go to IDLE.
- CTRACK outside REQ is ignored.
- Priority is strictly fixed. A continuously nonzero X starves Y and Z; this is intended behaviour.
- Sign reversal during REQ: the latched direction is still serviced, and the count moves accordingly (e.g. pending 0 then MINC ack gives +1? no: pending goes 0 -> +1 for MINC ack, 0 -> -1 for PINC ack). The pending count therefore stays arithmetically exact.
- FLCLR=1 clears both flags. If a set condition occurs in the same cycle, the set wins.

## Timing
- Reset values:
  - State IDLE.
  - CTRREQ=0, CTRADR=0, PINC=0, MINC=0.
  - PIPAFL=0, PENDOV=0.
  - PENDX/Y/Z=0.
- Reset asserted mid-REQ: CTRREQ falls after that edge and all pending counts are discarded.
- Latency: PIPSAM at edge n updates pending at n+1. CTRREQ is high after edge n+2, provided the FSM was idle.
- Throughput: with CTRACK at edge k, GAP follows. The earliest next CTRREQ is after edge k+2, giving one service per 3 cycles.
- Outputs are registered. There are no combinational paths from inputs to outputs.
- Flags assert the cycle after the triggering edge.

## Test plan
- Reset with PIPSAM pulses present: all outputs 0 during reset. After release, the first PIPSAM with PIPAXp_=0 raises CTRREQ=1, CTRADR=0, PINC=1 after 2 edges.
- Three +X samples and one -Y sample, then CTRACK asserted whenever CTRREQ=1: service order X,X,X,Y(MINC), spaced 3 cycles apart. Final pending is all zero.
- Acknowledge held off for 10 cycles with +1 Z pending and a -Z sample arriving during REQ: CTRREQ, CTRADR=2, PINC stay stable. After the ack, PENDZ=-1, followed by a MINC request.
- 9 consecutive +X samples with no ack: PENDX saturates at +7 and PENDOV=1. FLCLR pulse clears PENDOV; PENDX remains +7.
- PIPAYp_=PIPAYm_=0 at PIPSAM: PIPAFL=1 and PENDY unchanged. FLCLR in the same cycle as another fail leaves PIPAFL=1.
- Same-cycle sample +1 and PINC ack on X with PENDX=+2: PENDX stays +2, and the next request is again X PINC.

Source files
------------

// File: rtl/pipa_counter_sequencer.sv
// rtl/pipa_counter_sequencer.sv - PIPA pulse accumulator and counter-cycle request sequencer
module pipa_counter_sequencer #(
  parameter int PEND_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              PIPSAM,
  input  logic              PIPAXp_,
  input  logic              PIPAXm_,
  input  logic              PIPAYp_,
  input  logic              PIPAYm_,
  input  logic              PIPAZp_,
  input  logic              PIPAZm_,
  input  logic              CTRACK,
  input  logic              FLCLR,
  output logic              CTRREQ,
  output logic [1:0]        CTRADR,
  output logic              PINC,
  output logic              MINC,
  output logic              PIPAFL,
  output logic              PENDOV,
  output logic [PEND_W-1:0] PENDX,
  output logic [PEND_W-1:0] PENDY,
  output logic [PEND_W-1:0] PENDZ
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  // Two guard bits hold old + sample - ack before clamping.
  localparam int SW = PEND_W + 2;
  localparam logic signed [SW-1:0] SUM_MAX = {3'b000, {(PEND_W-1){1'b1}}};
  localparam logic signed [SW-1:0] SUM_MIN = {3'b111, {(PEND_W-1){1'b0}}};
  localparam logic signed [SW-1:0] SUM_ONE = {{(SW-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [1:0]        adr_q, adr_d;
  logic              pinc_q, pinc_d;
  logic [PEND_W-1:0] pend_q [3];
  logic [PEND_W-1:0] pend_d [3];
  logic [2:0]        sat;
  logic [2:0]        p_line, m_line;
  logic              pair_fail;
  logic              pipafl_q, pendov_q;

  assign p_line    = {PIPAZp_, PIPAYp_, PIPAXp_};
  assign m_line    = {PIPAZm_, PIPAYm_, PIPAXm_};
  assign pair_fail = PIPSAM & (|(~p_line & ~m_line));

  // Per-axis pending arithmetic: add the sampled pulse, remove the serviced increment, clamp.
  always_comb begin
    logic signed [SW-1:0] sum;
    logic signed [SW-1:0] sdel;
    logic signed [SW-1:0] adel;
    sat    = '0;
    pend_d = '{default: '0};
    sum    = '0;
    sdel   = '0;
    adel   = '0;
    for (int i = 0; i < 3; i++) begin
      sdel = '0;
      adel = '0;
      if (PIPSAM) begin
        if (!p_line[i] && m_line[i]) begin
          sdel = SUM_ONE;
        end else if (p_line[i] && !m_line[i]) begin
          sdel = '1;
        end
      end
      if (state_q == S_REQ && CTRACK && adr_q == 2'(i)) begin
        adel = pinc_q ? SUM_ONE : '1;
      end
      sum = {{2{pend_q[i][PEND_W-1]}}, pend_q[i]} + sdel - adel;
      pend_d[i] = sum[PEND_W-1:0];
      if (sum > SUM_MAX) begin
        pend_d[i] = SUM_MAX[PEND_W-1:0];
        sat[i]    = 1'b1;
      end else if (sum < SUM_MIN) begin
        pend_d[i] = SUM_MIN[PEND_W-1:0];
        sat[i]    = 1'b1;
      end
    end
  end

  // Request sequencing: fixed X>Y>Z pick from registered counts, hold until ack, one idle gap.
  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    pinc_d  = pinc_q;
    case (state_q)
      S_IDLE: begin
        if (pend_q[0] != '0) begin
          adr_d   = 2'd0;
          pinc_d  = ~pend_q[0][PEND_W-1];
          state_d = S_REQ;
        end else if (pend_q[1] != '0) begin
          adr_d   = 2'd1;
          pinc_d  = ~pend_q[1][PEND_W-1];
          state_d = S_REQ;
        end else if (pend_q[2] != '0) begin
          adr_d   = 2'd2;
          pinc_d  = ~pend_q[2][PEND_W-1];
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (CTRACK) begin
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, latched request, pending counts and sticky flags; a flag set beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      adr_q    <= 2'd0;
      pinc_q   <= 1'b0;
      pend_q   <= '{default: '0};
      pipafl_q <= 1'b0;
      pendov_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      adr_q    <= adr_d;
      pinc_q   <= pinc_d;
      pend_q   <= pend_d;
      pipafl_q <= pair_fail | (pipafl_q & ~FLCLR);
      pendov_q <= (|sat) | (pendov_q & ~FLCLR);
    end
  end

  assign CTRREQ = (state_q == S_REQ);
  assign CTRADR = adr_q;
  assign PINC   = CTRREQ & pinc_q;
  assign MINC   = CTRREQ & ~pinc_q;
  assign PIPAFL = pipafl_q;
  assign PENDOV = pendov_q;
  assign PENDX  = pend_q[0];
  assign PENDY  = pend_q[1];
  assign PENDZ  = pend_q[2];

endmodule

// File: tb/tb_pipa_counter_sequencer.sv
// tb/tb_pipa_counter_sequencer.sv - self-checking bench for pipa_counter_sequencer
module tb_pipa_counter_sequencer;

  logic       clk = 1'b0;
  logic       rst, PIPSAM, CTRACK, FLCLR;
  logic       PIPAXp_, PIPAXm_, PIPAYp_, PIPAYm_, PIPAZp_, PIPAZm_;
  logic       CTRREQ, PINC, MINC, PIPAFL, PENDOV;
  logic [1:0] CTRADR;
  logic [3:0] PENDX, PENDY, PENDZ;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: plain integer counts and a busy/gap service tracker.
  int m_pend [3];
  bit m_busy, m_gap, m_pinc, m_fl, m_ov;
  int m_axis;

  always #5 clk = ~clk;

  pipa_counter_sequencer #(.PEND_W(4)) dut (
    .clk(clk), .rst(rst), .PIPSAM(PIPSAM),
    .PIPAXp_(PIPAXp_), .PIPAXm_(PIPAXm_),
    .PIPAYp_(PIPAYp_), .PIPAYm_(PIPAYm_),
    .PIPAZp_(PIPAZp_), .PIPAZm_(PIPAZm_),
    .CTRACK(CTRACK), .FLCLR(FLCLR),
    .CTRREQ(CTRREQ), .CTRADR(CTRADR), .PINC(PINC), .MINC(MINC),
    .PIPAFL(PIPAFL), .PENDOV(PENDOV),
    .PENDX(PENDX), .PENDY(PENDY), .PENDZ(PENDZ)
  );

  // v: +1 plus pulse, -1 minus pulse, 0 none, 2 both lines low
  task automatic set_axis(input int axis, input int v);
    logic p, m;
    p = !(v == 1 || v == 2);
    m = !(v == -1 || v == 2);
    case (axis)
      0: begin PIPAXp_ = p; PIPAXm_ = m; end
      1: begin PIPAYp_ = p; PIPAYm_ = m; end
      default: begin PIPAZp_ = p; PIPAZm_ = m; end
    endcase
  endtask

  task automatic quiet();
    rst = 1'b0; PIPSAM = 1'b0; CTRACK = 1'b0; FLCLR = 1'b0;
    set_axis(0, 0); set_axis(1, 0); set_axis(2, 0);
  endtask

  task automatic sample(input int x, input int y, input int z);
    PIPSAM = 1'b1;
    set_axis(0, x); set_axis(1, y); set_axis(2, z);
  endtask

  // One clock edge for DUT and model alike, then settle 1 time unit past the edge.
  task automatic step();
    bit pl [3];
    bit ml [3];
    int old [3];
    int ad [3];
    int d, nv;
    bit fl_set, ov_set, r, s, a, c;
    pl = '{PIPAXp_, PIPAYp_, PIPAZp_};
    ml = '{PIPAXm_, PIPAYm_, PIPAZm_};
    r = rst; s = PIPSAM; a = CTRACK; c = FLCLR;
    @(posedge clk);
    if (r) begin
      m_pend = '{0, 0, 0};
      m_busy = 0; m_gap = 0; m_pinc = 0; m_axis = 0; m_fl = 0; m_ov = 0;
    end else begin
      old = m_pend;
      fl_set = 0; ov_set = 0;
      ad = '{0, 0, 0};
      if (m_busy && a) ad[m_axis] = m_pinc ? 1 : -1;
      for (int k = 0; k < 3; k++) begin
        d = 0;
        if (s) begin
          if (!pl[k] && ml[k]) d = 1;
          else if (pl[k] && !ml[k]) d = -1;
          else if (!pl[k] && !ml[k]) fl_set = 1;
        end
        nv = old[k] + d - ad[k];
        if (nv > 7) begin nv = 7; ov_set = 1; end
        if (nv < -8) begin nv = -8; ov_set = 1; end
        m_pend[k] = nv;
      end
      if (m_gap) begin
        m_gap = 0;
      end else if (m_busy) begin
        if (a) begin m_busy = 0; m_gap = 1; end
      end else begin
        for (int k = 2; k >= 0; k--) begin
          if (old[k] != 0) begin m_busy = 1; m_axis = k; m_pinc = old[k] > 0; end
        end
      end
      m_fl = fl_set || (m_fl && !c);
      m_ov = ov_set || (m_ov && !c);
    end
    #1;
  endtask

  task automatic do_reset();
    quiet();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic wait_req(input int lim, output bit ok);
    int n;
    n = 0;
    ok = CTRREQ;
    while (!ok && n < lim) begin
      step();
      n++;
      ok = CTRREQ;
    end
  endtask

  task automatic test_reset();
    quiet();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sample($urandom_range(0, 2) - 1, $urandom_range(0, 2) - 1, $urandom_range(0, 2) - 1);
      step();
      n_cmp++;
      if ({CTRREQ, CTRADR, PINC, MINC, PIPAFL, PENDOV, PENDX, PENDY, PENDZ} !== 18'd0) begin
        n_bad++;
        $display("FAIL reset_outputs act=%h exp=0", {CTRREQ, CTRADR, PINC, MINC, PIPAFL, PENDOV, PENDX, PENDY, PENDZ});
      end
    end
    quiet();
    sample(1, 0, 0);
    step();
    quiet();
    n_cmp++;
    if (PENDX !== 4'd1 || CTRREQ !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_first_edge act=PENDX%0d/REQ%b exp=PENDX1/REQ0", PENDX, CTRREQ);
    end
    step();
    n_cmp++;
    if ({CTRREQ, CTRADR, PINC, MINC} !== 5'b1_00_1_0) begin
      n_bad++;
      $display("FAIL reset_first_req act=%b exp=10010", {CTRREQ, CTRADR, PINC, MINC});
    end
  endtask

  task automatic test_sequence();
    int t_q [$];
    int a_q [$];
    int p_q [$];
    int exp_a [4];
    int exp_p [4];
    int n;
    exp_a = '{0, 0, 0, 1};
    exp_p = '{1, 1, 1, 0};
    do_reset();
    for (int i = 0; i < 30; i++) begin
      quiet();
      if (i < 3) sample(1, 0, 0);
      else if (i == 3) sample(0, -1, 0);
      CTRACK = CTRREQ;
      if (CTRREQ) begin t_q.push_back(i); a_q.push_back(CTRADR); p_q.push_back(PINC); end
      step();
    end
    quiet();
    n_cmp++;
    if (t_q.size() != 4) begin
      n_bad++;
      $display("FAIL seq_count act=%0d exp=4", t_q.size());
    end
    n = (t_q.size() < 4) ? t_q.size() : 4;
    for (int k = 0; k < n; k++) begin
      n_cmp++;
      if (a_q[k] != exp_a[k] || p_q[k] != exp_p[k]) begin
        n_bad++;
        $display("FAIL seq_order[%0d] act=adr%0d/pinc%0d exp=adr%0d/pinc%0d", k, a_q[k], p_q[k], exp_a[k], exp_p[k]);
      end
      if (k > 0) begin
        n_cmp++;
        if (t_q[k] - t_q[k-1] != 3) begin
          n_bad++;
          $display("FAIL seq_spacing[%0d] act=%0d exp=3", k, t_q[k] - t_q[k-1]);
        end
      end
    end
    n_cmp++;
    if ({PENDX, PENDY, PENDZ} !== 12'd0) begin
      n_bad++;
      $display("FAIL seq_final_pend act=%h exp=000", {PENDX, PENDY, PENDZ});
    end
  endtask

  task automatic test_hold();
    bit ok;
    do_reset();
    sample(0, 0, 1);
    step();
    quiet();
    wait_req(5, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL hold_req_timeout act=0 exp=1"); end
    for (int i = 0; i < 10; i++) begin
      quiet();
      if (i == 4) sample(0, 0, -1);
      step();
      n_cmp++;
      if ({CTRREQ, CTRADR, PINC, MINC} !== 5'b1_10_1_0) begin
        n_bad++;
        $display("FAIL hold_stable[%0d] act=%b exp=11010", i, {CTRREQ, CTRADR, PINC, MINC});
      end
    end
    n_cmp++;
    if (PENDZ !== 4'd0) begin n_bad++; $display("FAIL hold_pendz_mid act=%0d exp=0", PENDZ); end
    quiet();
    CTRACK = 1'b1;
    step();
    quiet();
    n_cmp++;
    if (PENDZ !== 4'hF || CTRREQ !== 1'b0) begin
      n_bad++;
      $display("FAIL hold_after_ack act=PENDZ%h/REQ%b exp=PENDZf/REQ0", PENDZ, CTRREQ);
    end
    wait_req(6, ok);
    n_cmp++;
    if (!ok || CTRADR !== 2'd2 || MINC !== 1'b1 || PINC !== 1'b0) begin
      n_bad++;
      $display("FAIL hold_minc_req act=ok%b/adr%0d/pm%b%b exp=ok1/adr2/pm01", ok, CTRADR, PINC, MINC);
    end
    CTRACK = 1'b1;
    step();
    quiet();
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 9; i++) begin
      sample(1, 0, 0);
      step();
      if (i == 6) begin
        n_cmp++;
        if (PENDX !== 4'd7 || PENDOV !== 1'b0) begin
          n_bad++;
          $display("FAIL sat_at_seven act=PENDX%0d/OV%b exp=PENDX7/OV0", PENDX, PENDOV);
        end
      end
    end
    quiet();
    n_cmp++;
    if (PENDX !== 4'd7 || PENDOV !== 1'b1 || CTRREQ !== 1'b1) begin
      n_bad++;
      $display("FAIL sat_clamp act=PENDX%0d/OV%b/REQ%b exp=PENDX7/OV1/REQ1", PENDX, PENDOV, CTRREQ);
    end
    FLCLR = 1'b1;
    step();
    quiet();
    n_cmp++;
    if (PENDX !== 4'd7 || PENDOV !== 1'b0) begin
      n_bad++;
      $display("FAIL sat_flclr act=PENDX%0d/OV%b exp=PENDX7/OV0", PENDX, PENDOV);
    end
  endtask

  task automatic test_pair_fail();
    do_reset();
    sample(0, 2, 0);
    step();
    quiet();
    n_cmp++;
    if (PIPAFL !== 1'b1 || PENDY !== 4'd0) begin
      n_bad++;
      $display("FAIL pair_set act=FL%b/PENDY%0d exp=FL1/PENDY0", PIPAFL, PENDY);
    end
    sample(2, 0, 0);
    FLCLR = 1'b1;
    step();
    quiet();
    n_cmp++;
    if (PIPAFL !== 1'b1 || PENDX !== 4'd0) begin
      n_bad++;
      $display("FAIL pair_set_wins act=FL%b/PENDX%0d exp=FL1/PENDX0", PIPAFL, PENDX);
    end
    FLCLR = 1'b1;
    step();
    quiet();
    n_cmp++;
    if (PIPAFL !== 1'b0 || PENDOV !== 1'b0) begin
      n_bad++;
      $display("FAIL pair_clear act=FL%b/OV%b exp=FL0/OV0", PIPAFL, PENDOV);
    end
  endtask

  task automatic test_same_cycle();
    bit ok;
    do_reset();
    sample(1, 0, 0);
    step();
    sample(1, 0, 0);
    step();
    n_cmp++;
    if (PENDX !== 4'd2 || CTRREQ !== 1'b1 || PINC !== 1'b1) begin
      n_bad++;
      $display("FAIL same_setup act=PENDX%0d/REQ%b/PINC%b exp=PENDX2/REQ1/PINC1", PENDX, CTRREQ, PINC);
    end
    sample(1, 0, 0);
    CTRACK = 1'b1;
    step();
    quiet();
    n_cmp++;
    if (PENDX !== 4'd2 || CTRREQ !== 1'b0) begin
      n_bad++;
      $display("FAIL same_cycle_pend act=PENDX%0d/REQ%b exp=PENDX2/REQ0", PENDX, CTRREQ);
    end
    wait_req(5, ok);
    n_cmp++;
    if (!ok || CTRADR !== 2'd0 || PINC !== 1'b1) begin
      n_bad++;
      $display("FAIL same_next_req act=ok%b/adr%0d/PINC%b exp=ok1/adr0/PINC1", ok, CTRADR, PINC);
    end
  endtask

  task automatic test_random();
    int v;
    logic [4:0] exp_hs;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      quiet();
      rst = ($urandom_range(0, 149) == 0);
      PIPSAM = ($urandom_range(0, 2) == 0);
      for (int k = 0; k < 3; k++) begin
        v = $urandom_range(0, 15);
        set_axis(k, (v < 6) ? 1 : (v < 12) ? -1 : (v < 15) ? 0 : 2);
      end
      CTRACK = $urandom_range(0, 1);
      FLCLR = ($urandom_range(0, 19) == 0);
      step();
      exp_hs = {m_busy, 2'(m_axis), m_busy && m_pinc, m_busy && !m_pinc};
      n_cmp++;
      if ({CTRREQ, CTRADR, PINC, MINC} !== exp_hs) begin
        n_bad++;
        $display("FAIL rnd_handshake cyc=%0d act=%b exp=%b", i, {CTRREQ, CTRADR, PINC, MINC}, exp_hs);
      end
      n_cmp++;
      if (PENDX !== 4'(m_pend[0]) || PENDY !== 4'(m_pend[1]) || PENDZ !== 4'(m_pend[2])) begin
        n_bad++;
        $display("FAIL rnd_pend cyc=%0d act=%h%h%h exp=%h%h%h", i, PENDX, PENDY, PENDZ,
                 4'(m_pend[0]), 4'(m_pend[1]), 4'(m_pend[2]));
      end
      n_cmp++;
      if (PIPAFL !== m_fl || PENDOV !== m_ov) begin
        n_bad++;
        $display("FAIL rnd_flags cyc=%0d act=%b%b exp=%b%b", i, PIPAFL, PENDOV, m_fl, m_ov);
      end
    end
    quiet();
  endtask

  initial begin
    quiet();
    test_reset();
    test_sequence();
    test_hold();
    test_saturation();
    test_pair_fail();
    test_same_cycle();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
